// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the multi-cycle MIPS core blocks:
//   - pc_src_e : next-PC source select encoding driven by the control FSM
//   - pc_act_e : the single PC-register action chosen in a given cycle
//   - default reset and exception vectors for the program counter
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'b00,   // PC + 4
        PC_SRC_BR  = 2'b01,   // branch target (ALUOut)
        PC_SRC_J   = 2'b10,   // pseudo-direct jump
        PC_SRC_JR  = 2'b11    // register jump (rs)
    } pc_src_e;

    typedef enum logic [2:0] {
        PC_ACT_HOLD     = 3'd0,
        PC_ACT_EXC      = 3'd1,
        PC_ACT_ERET     = 3'd2,
        PC_ACT_ADDR_ERR = 3'd3,
        PC_ACT_TAKE     = 3'd4
    } pc_act_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

endpackage : cpu_pkg

// File: rtl/pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
// Combinational next-PC selection for the multi-cycle core, including the
// construction of the pseudo-direct jump target.
// Ports:
//   pc_src     in  2       source select (see cpu_pkg::pc_src_e)
//   pc_plus4   in  ADDR_W  sequential next address
//   branch_tgt in  ADDR_W  branch target from ALUOut
//   jtarget    in  26      instruction[25:0]
//   reg_tgt    in  ADDR_W  rs value for jr
//   next_pc    out ADDR_W  selected next PC
// ----------------------------------------------------------------------------
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] branch_tgt,
    input  logic [25:0]       jtarget,
    input  logic [ADDR_W-1:0] reg_tgt,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_tgt;

    // Jumps keep the region bits of PC+4 above bit 27; narrower PCs simply
    // drop the top of the shifted 26-bit field.
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign jump_tgt = {pc_plus4[ADDR_W-1:28], jtarget, 2'b00};
        end else begin : g_jump_trunc
            logic [27:0] jump_full;
            assign jump_full = {jtarget, 2'b00};
            assign jump_tgt  = jump_full[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src_e'(pc_src))
            PC_SRC_SEQ: next_pc = pc_plus4;
            PC_SRC_BR:  next_pc = branch_tgt;
            PC_SRC_J:   next_pc = jump_tgt;
            PC_SRC_JR:  next_pc = reg_tgt;
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule : pc_next_mux

// File: rtl/pc_ctrl.sv
// ----------------------------------------------------------------------------
// pc_ctrl
// Program-counter unit for the multi-cycle MIPS core. Holds the fetch
// address, selects the next PC under PCWrite/PCWriteCond control, and handles
// exception entry, eret and misaligned-target faults (EPC / BadVAddr capture).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   pc_write           unconditional PC update
//   pc_write_cond      conditional (branch) update
//   branch_ne, zero    branch condition: take when zero ^ branch_ne
//   pc_src             next-PC source select
//   branch_tgt, jtarget, reg_tgt   candidate targets
//   exc_req, eret      exception entry / return
//   pc, pc_plus4       current PC and PC+4 (combinational, wraps)
//   epc, badvaddr      saved exception PC and last misaligned target
//   addr_err           one-cycle pulse on a misaligned taken target
// ----------------------------------------------------------------------------
module pc_ctrl
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_write,
    input  logic              pc_write_cond,
    input  logic              branch_ne,
    input  logic              zero,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] branch_tgt,
    input  logic [25:0]       jtarget,
    input  logic [ADDR_W-1:0] reg_tgt,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] FOUR   = {{(ADDR_W-3){1'b0}}, 3'd4};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W-1:0] next_pc;
    logic              take;
    logic              misaligned;
    pc_act_e           act;

    assign pc_plus4 = pc_q + FOUR;

    pc_next_mux #(
        .ADDR_W (ADDR_W)
    ) u_next_mux (
        .pc_src     (pc_src),
        .pc_plus4   (pc_plus4),
        .branch_tgt (branch_tgt),
        .jtarget    (jtarget),
        .reg_tgt    (reg_tgt),
        .next_pc    (next_pc)
    );

    // A not-taken branch never reaches the alignment check, so a junk
    // branch target on a false condition cannot raise a fault.
    assign take       = pc_write | (pc_write_cond & (zero ^ branch_ne));
    assign misaligned = take & (next_pc[1:0] != 2'b00);

    always_comb begin
        act = PC_ACT_HOLD;
        if (exc_req) begin
            act = PC_ACT_EXC;
        end else if (eret) begin
            act = PC_ACT_ERET;
        end else if (misaligned) begin
            act = PC_ACT_ADDR_ERR;
        end else if (take) begin
            act = PC_ACT_TAKE;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        addr_err_d = 1'b0;
        case (act)
            PC_ACT_EXC: begin
                epc_d = pc_q;
                pc_d  = EXC_PC;
            end
            PC_ACT_ERET: begin
                pc_d = epc_q;
            end
            PC_ACT_ADDR_ERR: begin
                badvaddr_d = next_pc;
                epc_d      = pc_q;
                pc_d       = EXC_PC;
                addr_err_d = 1'b1;
            end
            PC_ACT_TAKE: begin
                pc_d = next_pc;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RST_PC;
            epc_q      <= '0;
            badvaddr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign badvaddr = badvaddr_q;
    assign addr_err = addr_err_q;

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_ctrl
// Directed scenarios followed by randomized cycles for pc_ctrl (ADDR_W = 32),
// each cycle compared against a behavioural model of the PC unit.
// ----------------------------------------------------------------------------
module tb_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic        zero;
    logic [1:0]  pc_src;
    logic [31:0] branch_tgt;
    logic [25:0] jtarget;
    logic [31:0] reg_tgt;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference state
    logic [31:0] m_pc, m_epc, m_bad;
    logic        m_err;

    pc_ctrl #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0000_0000),
        .EXC_VEC   (32'h0000_0080)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .pc_src        (pc_src),
        .branch_tgt    (branch_tgt),
        .jtarget       (jtarget),
        .reg_tgt       (reg_tgt),
        .exc_req       (exc_req),
        .eret          (eret),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .badvaddr      (badvaddr),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; pc_write = 1'b0; pc_write_cond = 1'b0; branch_ne = 1'b0;
        zero = 1'b0; pc_src = 2'b00; branch_tgt = '0; jtarget = '0;
        reg_tgt = '0; exc_req = 1'b0; eret = 1'b0;
    endtask

    // One clock: advance the model from the currently driven inputs, clock
    // the DUT, then compare every output 1 ns after the edge.
    task automatic step();
        logic        t;
        logic [31:0] nxt;
        t = pc_write | (pc_write_cond & (zero != branch_ne));
        case (pc_src)
            2'd0: nxt = m_pc + 32'd4;
            2'd1: nxt = branch_tgt;
            2'd2: nxt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jtarget) * 32'd4);
            default: nxt = reg_tgt;
        endcase
        m_err = 1'b0;
        if (!rst_n) begin
            m_pc = 32'h0; m_epc = 32'h0; m_bad = 32'h0;
        end else if (exc_req) begin
            m_epc = m_pc; m_pc = 32'h80;
        end else if (eret) begin
            m_pc = m_epc;
        end else if (t && (nxt % 4 != 0)) begin
            m_bad = nxt; m_epc = m_pc; m_pc = 32'h80; m_err = 1'b1;
        end else if (t) begin
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d rst_n=%b wr=%b wc=%b src=%0d exc=%b eret=%b -> pc=%h epc=%h bad=%h err=%b",
                 n_txn, rst_n, pc_write, pc_write_cond, pc_src, exc_req, eret,
                 pc, epc, badvaddr, addr_err);
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("epc", epc, m_epc);
        check_eq("badvaddr", badvaddr, m_bad);
        check_eq("addr_err", {31'b0, addr_err}, {31'b0, m_err});
    endtask

    task automatic jr_to(input logic [31:0] a);
        idle_inputs();
        pc_write = 1'b1; pc_src = 2'b11; reg_tgt = a;
        step();
        idle_inputs();
    endtask

    initial begin
        m_pc = '0; m_epc = '0; m_bad = '0; m_err = 1'b0;
        idle_inputs();
        #1;

        // 1. Reset with pc_write active, then sequential fetch
        rst_n = 1'b0; pc_write = 1'b1;
        step(); step();
        check_eq("reset_pc", pc, 32'h0);
        rst_n = 1'b1; pc_write = 1'b1; pc_src = 2'b00;
        step(); check_eq("seq_4", pc, 32'h4);
        step(); check_eq("seq_8", pc, 32'h8);
        step(); check_eq("seq_12", pc, 32'hC);
        pc_write = 1'b0;
        step(); check_eq("seq_hold", pc, 32'hC);

        // 2. Branch decisions
        jr_to(32'h10);
        pc_write_cond = 1'b1; pc_src = 2'b01; branch_tgt = 32'h40;
        zero = 1'b1; branch_ne = 1'b0;
        step(); check_eq("beq_taken", pc, 32'h40);
        zero = 1'b1; branch_ne = 1'b1;
        step(); check_eq("bne_not_taken", pc, 32'h40);
        zero = 1'b0; branch_ne = 1'b1; branch_tgt = 32'h80;
        step(); check_eq("bne_taken", pc, 32'h80);
        // not-taken branch to a misaligned target: no fault
        zero = 1'b1; branch_ne = 1'b1; branch_tgt = 32'h83;
        step(); check_eq("nt_misaligned_err", {31'b0, addr_err}, 32'h0);
        idle_inputs();

        // 3. Jump keeps the PC+4 region bits
        jr_to(32'h1000_0000);
        pc_write = 1'b1; pc_src = 2'b10; jtarget = 26'h0000100;
        step(); check_eq("jump", pc, 32'h1000_0400);
        idle_inputs();

        // 4. Misaligned jr
        jr_to(32'h20);
        pc_write = 1'b1; pc_src = 2'b11; reg_tgt = 32'h33;
        step();
        check_eq("mis_pc", pc, 32'h80);
        check_eq("mis_epc", epc, 32'h20);
        check_eq("mis_bad", badvaddr, 32'h33);
        check_eq("mis_err", {31'b0, addr_err}, 32'h1);
        idle_inputs();
        step(); check_eq("mis_err_pulse_end", {31'b0, addr_err}, 32'h0);

        // 5. Exception priority and return
        jr_to(32'h44);
        exc_req = 1'b1; pc_write = 1'b1; pc_src = 2'b00;
        step(); check_eq("exc_pc", pc, 32'h80); check_eq("exc_epc", epc, 32'h44);
        exc_req = 1'b0; eret = 1'b1; pc_write = 1'b1;
        step(); check_eq("eret_pc", pc, 32'h44);
        exc_req = 1'b1; eret = 1'b1; pc_write = 1'b0;
        step(); check_eq("exc_over_eret", pc, 32'h80); check_eq("exc_over_eret_epc", epc, 32'h44);
        idle_inputs();

        // 6. Wrap, then reset concurrent with an exception
        jr_to(32'hFFFF_FFFC);
        pc_write = 1'b1; pc_src = 2'b00;
        step(); check_eq("wrap_pc", pc, 32'h0); check_eq("wrap_err", {31'b0, addr_err}, 32'h0);
        jr_to(32'h48);
        rst_n = 1'b0; exc_req = 1'b1;
        step();
        check_eq("rst_exc_pc", pc, 32'h0); check_eq("rst_exc_epc", epc, 32'h0);
        check_eq("rst_exc_err", {31'b0, addr_err}, 32'h0);
        idle_inputs();

        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            rst_n         = ($urandom_range(0, 49) != 0);
            pc_write      = ($urandom_range(0, 2) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            branch_ne     = 1'($urandom);
            zero          = 1'($urandom);
            pc_src        = 2'($urandom);
            branch_tgt    = $urandom & ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            reg_tgt       = $urandom & ($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jtarget       = 26'($urandom);
            exc_req       = ($urandom_range(0, 19) == 0);
            eret          = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_ctrl
